// File: rtl/lib_pkg.sv
// rtl/lib_pkg.sv - shared ALU operation encoding
package lib_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } op_type_t;

endpackage

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM/LUI decode into a 2-entry skid buffer feeding the ALU
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (adds out_illegal and its per-entry storage).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous flush, empties both entries
//   in_valid/in_ready     upstream handshake; in_instr, in_rs1_val, in_rs2_val carried with it
//   out_valid/out_ready   downstream handshake toward the ALU
//   out_op, out_in0/1     ALU operation and operands
//   out_rd, out_we        destination register and write enable
//   out_illegal           unsupported encoding flag (macro builds only)
module alu_issue_stage
    import lib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output op_type_t         out_op,
    output logic [WIDTH-1:0] out_in0,
    output logic [WIDTH-1:0] out_in1,
    output logic [4:0]       out_rd,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic             out_illegal,
`endif
    output logic             out_we
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef struct packed {
        op_type_t         op;
        logic [WIDTH-1:0] in0;
        logic [WIDTH-1:0] in1;
        logic [4:0]       rd;
        logic             we;
    } entry_t;

    localparam entry_t ENTRY_RST = '{op: OP_ADD, in0: '0, in1: '0, rd: 5'd0, we: 1'b0};

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, dec;
    logic   dec_legal;
    logic   fire_in, fire_out;
    logic   load_main, load_skid;

    // funct3 -> operation; alt selects SUB/SRA on the 000/101 slots
    function automatic op_type_t alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // ---------------- decode ----------------
    logic [6:0] f7;
    logic [2:0] f3;
    assign f7 = in_instr[31:25];
    assign f3 = in_instr[14:12];

    always_comb begin
        dec_legal = 1'b0;
        dec.op    = OP_ADD;
        dec.in0   = in_rs1_val;
        dec.in1   = in_rs2_val;
        dec.rd    = in_instr[11:7];
        case (in_instr[6:0])
            OPC_OP: begin
                dec_legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                dec.op    = alu_op(f3, f7[5]);
            end
            OPC_IMM: begin
                dec.in1 = WIDTH'($signed(in_instr[31:20]));
                case (f3)
                    3'b001:  dec_legal = (f7 == 7'h00);
                    3'b101:  dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    default: dec_legal = 1'b1;
                endcase
                // addi has no subtract form; only the shift slot honours funct7
                dec.op = alu_op(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec.in0   = '0;
                dec.in1   = WIDTH'($signed({in_instr[31:12], 12'h000}));
            end
            default: ;
        endcase
        // unsupported encodings travel as a NOP
        if (!dec_legal) begin
            dec.op  = OP_ADD;
            dec.in0 = '0;
            dec.in1 = '0;
        end
        dec.we = dec_legal && (in_instr[11:7] != 5'd0);
    end

    // ---------------- FSM ----------------
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (fire_in) state_nxt = S_ONE;
                S_ONE: begin
                    if (fire_in && !fire_out)      state_nxt = S_FULL;
                    else if (!fire_in && fire_out) state_nxt = S_EMPTY;
                end
                S_FULL:  if (fire_out) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        // rst_n gates in_ready so nothing is taken while reset is held
        in_ready  = rst_n && (state != S_FULL);
        out_valid = (state != S_EMPTY);
        load_main = !flush && (((state == S_EMPTY) && fire_in) ||
                               ((state == S_ONE) && fire_in && fire_out) ||
                               ((state == S_FULL) && fire_out));
        load_skid = !flush && (state == S_ONE) && fire_in && !fire_out;
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else begin
            if (load_main) main_q <= (state == S_FULL) ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic main_ill, skid_ill;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ill <= 1'b0;
            skid_ill <= 1'b0;
        end else begin
            if (load_main) main_ill <= (state == S_FULL) ? skid_ill : !dec_legal;
            if (load_skid) skid_ill <= !dec_legal;
        end
    end
    assign out_illegal = main_ill;
`endif

    assign out_op  = main_q.op;
    assign out_in0 = main_q.in0;
    assign out_in1 = main_q.in1;
    assign out_rd  = main_q.rd;
    assign out_we  = main_q.we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
    import lib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1_val = '0;
    logic [31:0] in_rs2_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    op_type_t    out_op;
    logic [31:0] out_in0, out_in1;
    logic [4:0]  out_rd;
    logic        out_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_in0(out_in0), .out_in1(out_in1), .out_rd(out_rd),
`ifdef ALU_ISSUE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .out_we(out_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_type_t    op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the ALU should be told to do for one instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        op_type_t base[8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
        int opc = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        int imm = int'($signed(ins[31:20]));
        bit legal = 0;
        e.op = OP_ADD; e.in0 = 0; e.in1 = 0;
        if (opc == 'h33) begin
            legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.op = base[f3];
            if (f7 == 'h20 && f3 == 0) e.op = OP_SUB;
            if (f7 == 'h20 && f3 == 5) e.op = OP_SRA;
            e.in0 = a; e.in1 = b;
        end else if (opc == 'h13) begin
            if (f3 == 1)      legal = (f7 == 0);
            else if (f3 == 5) legal = (f7 == 0 || f7 == 'h20);
            else              legal = 1;
            e.op = base[f3];
            if (f3 == 5 && f7 == 'h20) e.op = OP_SRA;
            e.in0 = a; e.in1 = imm;
        end else if (opc == 'h37) begin
            legal = 1;
            e.in1 = int'(ins[31:12]) * 4096;
        end
        if (!legal) begin
            e.op = OP_ADD; e.in0 = 0; e.in1 = 0;
        end
        e.rd  = ins[11:7];
        e.we  = legal && (ins[11:7] != 0);
        e.ill = !legal;
        return e;
    endfunction

    // Input side: every accepted entry becomes an expectation
    always @(negedge clk) begin
        if (!rst_n || flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(in_instr, in_rs1_val, in_rs2_val));
    end

    // Output side: compare on every delivery, and check stability while stalled
    logic        hold_prev = 1'b0;
    logic [31:0] p_in0, p_in1;
    op_type_t    p_op;
    logic [4:0]  p_rd;
    logic        p_we;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_op", out_op, p_op);
            chk("hold_in0", out_in0, p_in0);
            chk("hold_in1", out_in1, p_in1);
            chk("hold_rd", {out_rd, out_we}, {p_rd, p_we});
        end
        if (rst_n && !flush && out_valid && out_ready) begin
            chk("sb_entry_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_op", out_op, e.op);
                chk("sb_in0", out_in0, e.in0);
                chk("sb_in1", out_in1, e.in1);
                chk("sb_rd", out_rd, e.rd);
                chk("sb_we", out_we, e.we);
`ifdef ALU_ISSUE_ILLEGAL_EN
                chk("sb_illegal", out_illegal, e.ill);
`endif
            end
        end
        hold_prev = rst_n && !flush && out_valid && !out_ready;
        p_op = out_op; p_in0 = out_in0; p_in1 = out_in1; p_rd = out_rd; p_we = out_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_instr = ins; in_rs1_val = a; in_rs2_val = b;
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  f7s[3];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = w[31:25];
        case ($urandom_range(0, 5))
            0, 1:    w = {f7s[$urandom_range(0, 2)], w[24:7], 7'b0110011};
            2, 3:    w = {f7s[$urandom_range(0, 2)], w[24:7], 7'b0010011};
            4:       w = {w[31:7], 7'b0110111};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [31:0] t3[3];
        logic r;

        // 1) reset state, then add x3,x1,x2
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_op", out_op, OP_ADD);
        chk("rst_out_in", {out_in0, out_in1}, 0);
        chk("rst_out_rd_we", {out_rd, out_we}, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("rst_out_illegal", out_illegal, 0);
`endif
        step(); rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(32'h002081B3, 5, 7);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_op", out_op, OP_ADD);
        chk("t1_in0", out_in0, 5);
        chk("t1_in1", out_in1, 7);
        chk("t1_rd_we", {out_rd, out_we}, {5'd3, 1'b1});

        // 2) addi x1,x0,-1 then srai x2,x2,4 back to back
        step(); drive(32'hFFF00093, 0, 9);
        step(); drive(32'h40415113, 32'h8000_0000, 0);
        @(negedge clk);
        chk("t2_addi_op", out_op, OP_ADD);
        chk("t2_addi_in1", out_in1, 32'hFFFF_FFFF);
        chk("t2_addi_we", out_we, 1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t2_srai_op", out_op, OP_SRA);
        chk("t2_srai_shamt", out_in1[4:0], 4);

        // 3) stalled consumer: only two of three entries fit
        step(); step();
        out_ready = 1'b0;
        t3[0] = mk_r(7'h00, 3'b000, 5'd5);
        t3[1] = mk_r(7'h20, 3'b000, 5'd6);
        t3[2] = mk_r(7'h00, 3'b111, 5'd7);
        acc = 0;
        drive(t3[0], 11, 22);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); r = in_ready;
            step();
            if (r) begin acc++; drive(t3[acc], 11 + acc, 22 + acc); end
        end
        @(negedge clk);
        chk("t3_accepted", acc, 2);
        chk("t3_full_ready", in_ready, 0);
        step(); out_ready = 1'b1;
        @(negedge clk);
        chk("t3_head_valid", out_valid, 1);
        step();
        @(negedge clk);
        chk("t3_ready_after_drain", in_ready, 1);
        step(); in_valid = 1'b0;
        repeat (3) step();

        // 4) flush while FULL with a simultaneous offer
        out_ready = 1'b0;
        drive(mk_r(7'h00, 3'b100, 5'd8), 1, 2);
        step(); drive(mk_r(7'h00, 3'b110, 5'd9), 3, 4);
        step(); drive(mk_r(7'h00, 3'b001, 5'd10), 5, 6);
        flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid_after_flush", out_valid, 0);
        chk("t4_ready_after_flush", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t4_nothing_emerges", out_valid, 0);

        // 5) ecall then add x0,x1,x2
        step(); drive(32'h0000_0073, 33, 44);
        step(); drive(32'h0020_8033, 33, 44);
        @(negedge clk);
        chk("t5_ecall_op", out_op, OP_ADD);
        chk("t5_ecall_ops", {out_in0, out_in1}, 0);
        chk("t5_ecall_we", out_we, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("t5_ecall_illegal", out_illegal, 1);
`endif
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t5_x0_we", out_we, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("t5_x0_illegal", out_illegal, 0);
`endif

        // 6) asynchronous reset while FULL
        step(); out_ready = 1'b0;
        drive(mk_r(7'h00, 3'b010, 5'd11), 7, 8);
        step(); drive(mk_r(7'h00, 3'b011, 5'd12), 9, 10);
        step(); in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_ready", in_ready, 0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after_rst", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t6_no_stale", out_valid, 0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            in_valid   = ($urandom_range(0, 99) < 70);
            in_instr   = rand_instr();
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            out_ready  = ($urandom_range(0, 99) < 60);
            flush      = ($urandom_range(0, 99) < 3);
        end
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        @(negedge clk);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
